lfa_share_arbiter: RTL and testbench

LFA_SHARE_ARBITER -- requirements
Module: lfa_share_arbiter

---
 rtl/lfa_share_arbiter.sv | 139 +++++++++++++
 tb/tb_lfa_share_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lfa_share_arbiter.sv
// Purpose: round-robin sharing of one pipelined W-bit adder among NREQ requesters; results return in issue order.
// Latency: grant in cycle t -> operands on adder_a/b in t+1 -> result on rsp_* in cycle t+2+LAT.
// Backpressure: a grant needs credit (in-flight + queued < DEPTH); rsp_ready only gates the FIFO pop.
// Ports: clk/rst (sync, active-low); req_valid/req_a/req_b/req_ready requester side (one-hot grant);
//        adder_a/adder_b/adder_sum/adder_cout shared adder; rsp_valid/rsp_ready/rsp_sum/rsp_cout/rsp_id
//        result FIFO head; busy = anything in flight or queued.
module lfa_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int W     = 16,
  parameter int LAT   = 3,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*W-1:0]       req_a,
  input  logic [NREQ*W-1:0]       req_b,
  output logic [NREQ-1:0]         req_ready,
  output logic [W-1:0]            adder_a,
  output logic [W-1:0]            adder_b,
  input  logic [W-1:0]            adder_sum,
  input  logic                    adder_cout,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [W-1:0]            rsp_sum,
  output logic                    rsp_cout,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic                    busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [W-1:0]   sum;
    logic           cout;
    logic [IDW-1:0] id;
  } rsp_t;

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] win;
  logic [IDW:0]   sum_idx;
  logic [IDW-1:0] cand;
  logic           found;
  logic           credit;
  logic           grant;
  int unsigned    inflight;

  // Stage 0 rides alongside adder_a/adder_b; stage LAT lines up with adder_sum.
  logic [LAT:0]   tag_vld;
  logic [IDW-1:0] tag_id [LAT+1];

  rsp_t           fifo_mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  fifo_cnt;
  logic           push;
  logic           pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Every launched operation reserves a FIFO slot until it is popped,
  // so the FIFO can never be written while full.
  always_comb begin
    inflight = 0;
    for (int s = 0; s <= LAT; s++) begin
      if (tag_vld[s]) inflight = inflight + 1;
    end
    credit = (inflight + 32'(fifo_cnt)) < 32'(DEPTH);
  end

  // Round-robin search starting at ptr, wrapping modulo NREQ.
  always_comb begin
    found   = 1'b0;
    win     = '0;
    sum_idx = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum_idx = {1'b0, ptr} + (IDW+1)'(k);
      cand    = (sum_idx >= (IDW+1)'(NREQ)) ? IDW'(sum_idx - (IDW+1)'(NREQ))
                                            : sum_idx[IDW-1:0];
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    grant     = found & credit & rst;
    req_ready = '0;
    if (grant) req_ready[win] = 1'b1;
  end

  assign push      = tag_vld[LAT];
  assign rsp_valid = (fifo_cnt != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign rsp_sum   = fifo_mem[rd_ptr].sum;
  assign rsp_cout  = fifo_mem[rd_ptr].cout;
  assign rsp_id    = fifo_mem[rd_ptr].id;
  assign busy      = (inflight != 0) || rsp_valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr      <= '0;
      tag_vld  <= '0;
      adder_a  <= '0;
      adder_b  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      tag_vld <= {tag_vld[LAT-1:0], grant};
      if (grant) begin
        ptr     <= (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
        adder_a <= req_a[int'(win)*W +: W];
        adder_b <= req_b[int'(win)*W +: W];
      end else begin
        adder_a <= '0;
        adder_b <= '0;
      end
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Payload storage needs no reset: validity lives in tag_vld and fifo_cnt.
  always_ff @(posedge clk) begin
    tag_id[0] <= win;
    for (int s = 1; s <= LAT; s++) tag_id[s] <= tag_id[s-1];
    if (push && rst) fifo_mem[wr_ptr] <= '{sum: adder_sum, cout: adder_cout, id: tag_id[LAT]};
  end

endmodule

// File: tb/tb_lfa_share_arbiter.sv
module tb_lfa_share_arbiter;
  localparam int NREQ = 4, W = 16, LAT = 3, DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [3:0]      req_valid;
  logic [63:0]     req_a, req_b;
  logic [3:0]      req_ready;
  logic [15:0]     adder_a, adder_b, adder_sum;
  logic            adder_cout;
  logic            rsp_valid, rsp_ready;
  logic [15:0]     rsp_sum;
  logic            rsp_cout;
  logic [1:0]      rsp_id;
  logic            busy;

  int total = 0;
  int passed = 0;

  lfa_share_arbiter #(.NREQ(NREQ), .W(W), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .adder_a(adder_a), .adder_b(adder_b), .adder_sum(adder_sum), .adder_cout(adder_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .rsp_id(rsp_id), .busy(busy)
  );

  // Behavioural adder: LAT register stages after the registered operands.
  logic [16:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= {1'b0, adder_a} + {1'b0, adder_b};
    for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
  end
  assign adder_sum  = pipe[LAT-1][15:0];
  assign adder_cout = pipe[LAT-1][16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic set_ops(input logic [15:0] a, input logic [15:0] b);
    for (int i = 0; i < 4; i++) begin
      req_a[i*16 +: 16] = a + 16'(i * 257);
      req_b[i*16 +: 16] = b;
    end
  endtask

  // Scoreboard: every transfer predicts one response, popped in issue order.
  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic [1:0]  id;
  } rsp_t;
  rsp_t        exp_q[$];
  rsp_t        sb_e;
  logic [16:0] sb_s;

  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
    end else begin
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_rsp: got id %0d sum 0x%0h, want no response", rsp_id, rsp_sum);
        end else begin
          sb_e = exp_q.pop_front();
          chk("rsp_order", {rsp_sum, rsp_cout, rsp_id}, sb_e);
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sb_s = {1'b0, req_a[i*16 +: 16]} + {1'b0, req_b[i*16 +: 16]};
          exp_q.push_back('{sum: sb_s[15:0], cout: sb_s[16], id: 2'(i)});
        end
      end
    end
  end

  typedef struct {
    logic [3:0] rv;
    logic [3:0] exp_rdy;
  } vec_t;
  vec_t tbl [13];

  int ngr;
  int exp_next;
  int nstale;

  initial begin
    // Round-robin pointer enters at 1; credit stalls where 4 slots are held.
    tbl[0]  = '{4'b1111, 4'b0010};
    tbl[1]  = '{4'b1111, 4'b0100};
    tbl[2]  = '{4'b0001, 4'b0001};
    tbl[3]  = '{4'b1000, 4'b1000};
    tbl[4]  = '{4'b1111, 4'b0000};
    tbl[5]  = '{4'b0110, 4'b0000};
    tbl[6]  = '{4'b0110, 4'b0010};
    tbl[7]  = '{4'b0110, 4'b0100};
    tbl[8]  = '{4'b0000, 4'b0000};
    tbl[9]  = '{4'b0101, 4'b0001};
    tbl[10] = '{4'b1001, 4'b1000};
    tbl[11] = '{4'b1111, 4'b0000};
    tbl[12] = '{4'b1111, 4'b0001};

    rst = 1'b0; req_valid = 4'hF; rsp_ready = 1'b0;
    set_ops(16'h0101, 16'h0202);
    step; step;
    settle;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_adder_a", adder_a, 0);
    chk("reset_adder_b", adder_b, 0);

    // Single request latency
    step; rst = 1'b1; req_valid = 4'h0;
    step; req_valid = 4'b0001; req_a = '0; req_b = '0;
    req_a[15:0] = 16'h1234; req_b[15:0] = 16'h0FFF;
    settle; chk("single_ready", req_ready, 4'b0001);
    step; req_valid = 4'h0;
    settle;
    chk("single_adder_a", adder_a, 16'h1234);
    chk("single_adder_b", adder_b, 16'h0FFF);
    chk("single_ready_once", req_ready, 0);
    step; settle; chk("single_busy", busy, 1);
    step;
    step; settle; chk("single_not_early", rsp_valid, 0);
    step; settle;
    chk("single_rsp_valid", rsp_valid, 1);
    chk("single_rsp_sum", rsp_sum, 16'h2233);
    chk("single_rsp_cout", rsp_cout, 0);
    chk("single_rsp_id", rsp_id, 0);
    step; rsp_ready = 1'b1; settle;
    step; settle;
    chk("single_drained", rsp_valid, 0);
    chk("single_idle", busy, 0);

    // Arbitration and credit vectors
    for (int k = 0; k < 13; k++) begin
      step;
      req_valid = tbl[k].rv;
      set_ops(16'(k * 16'h1111), 16'hF00F);
      settle;
      chk($sformatf("arb_vec%0d", k), req_ready, tbl[k].exp_rdy);
    end

    // Fairness under continuous demand; ptr is 1 after the table
    step; req_valid = 4'h0;
    repeat (8) step;
    ngr = 0; exp_next = 1;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) step;
      req_valid = 4'hF;
      set_ops(16'(c * 16'h0731), 16'h1357);
      settle;
      if (req_ready != 4'h0) begin
        chk("fair_grant", req_ready, 4'b0001 << exp_next);
        exp_next = (exp_next + 1) % 4;
        ngr++;
      end
    end
    chk("fair_progress", ngr >= 8, 1);

    // Backpressure
    step; req_valid = 4'h0;
    repeat (8) step;
    settle; chk("bp_idle", busy, 0);
    ngr = 0;
    for (int c = 0; c < 12; c++) begin
      step; rsp_ready = 1'b0; req_valid = 4'hF; set_ops(16'h4000, 16'h0042);
      settle;
      if (req_ready != 4'h0) ngr++;
    end
    chk("bp_grants", ngr, 4);
    chk("bp_ready_zero", req_ready, 0);
    chk("bp_rsp_valid", rsp_valid, 1);
    ngr = 0;
    for (int c = 0; c < 9; c++) begin
      step; rsp_ready = (c == 0);
      settle;
      if (req_ready != 4'h0) ngr++;
    end
    chk("bp_one_more", ngr, 1);
    step; req_valid = 4'h0; rsp_ready = 1'b1;
    repeat (12) step;
    settle;
    chk("bp_drain_busy", busy, 0);
    chk("bp_sb_empty", exp_q.size(), 0);

    // Carry and ordering
    step; rsp_ready = 1'b0; req_valid = 4'b0100; req_a = '0; req_b = '0;
    req_a[32 +: 16] = 16'hFFFF; req_b[32 +: 16] = 16'h0001;
    settle; chk("co_ready_2", req_ready, 4'b0100);
    step; req_valid = 4'b0010;
    req_a[16 +: 16] = 16'h8000; req_b[16 +: 16] = 16'h8000;
    settle; chk("co_ready_1", req_ready, 4'b0010);
    step; req_valid = 4'h0;
    step; step; step;
    settle;
    chk("co_first", {rsp_valid, rsp_sum, rsp_cout, rsp_id}, {1'b1, 16'h0000, 1'b1, 2'd2});
    step; rsp_ready = 1'b1; settle;
    step; rsp_ready = 1'b0; settle;
    chk("co_second", {rsp_valid, rsp_sum, rsp_cout, rsp_id}, {1'b1, 16'h0000, 1'b1, 2'd1});
    step; rsp_ready = 1'b1;
    step; rsp_ready = 1'b0; settle;
    chk("co_empty", rsp_valid, 0);

    // Reset with one result queued and two in flight
    step; req_valid = 4'b0001; req_a = '0; req_b = '0; set_ops(16'h0001, 16'h0002);
    settle; chk("rm_grant_a", req_ready, 4'b0001);
    step; req_valid = 4'h0;
    step; step;
    step; req_valid = 4'b0010; settle; chk("rm_grant_b", req_ready, 4'b0010);
    step; req_valid = 4'b0100; settle; chk("rm_grant_c", req_ready, 4'b0100);
    step; req_valid = 4'hF; rst = 1'b0;
    settle;
    chk("rm_queued_before", rsp_valid, 1);
    chk("rm_ready_in_reset", req_ready, 0);
    step; rst = 1'b1; req_valid = 4'h0; rsp_ready = 1'b1;
    settle;
    chk("rm_rsp_valid", rsp_valid, 0);
    chk("rm_busy", busy, 0);
    nstale = 0;
    for (int c = 0; c < 10; c++) begin
      step; settle;
      if (rsp_valid) nstale++;
    end
    chk("rm_no_stale", nstale, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
